// File: rtl/vga_timing_if.sv
// Raster outputs of vga_timing as seen by the downstream pixel stage.
// master drives the signals (timing generator); slave consumes them (pixel stage).
interface vga_timing_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10,
    parameter int F_W = 5
);
    logic [X_W-1:0] pixel_x;
    logic [Y_W-1:0] pixel_y;
    logic           line_start;
    logic           frame_start;
    logic [F_W-1:0] frame_counter;
    logic           active;
    logic           hsync;
    logic           vsync;

    modport master (
        output pixel_x, pixel_y, line_start, frame_start,
               frame_counter, active, hsync, vsync
    );

    modport slave (
        input pixel_x, pixel_y, line_start, frame_start,
              frame_counter, active, hsync, vsync
    );
endinterface

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: zero-latency counters and strobes, plus
// hsync/vsync/active delayed PIPE_DELAY pixel clocks to match the colour pipeline.
module vga_timing #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FRONT_PORCH   = 16,
    parameter int H_SYNC_PULSE    = 96,
    parameter int H_BACK_PORCH    = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT_PORCH   = 10,
    parameter int V_SYNC_PULSE    = 2,
    parameter int V_BACK_PORCH    = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int PIPE_DELAY      = 1,
    parameter int FRAME_BITS      = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = $clog2(V_TOTAL);

    // Inclusive bounds so every constant fits the counter width even with zero porches.
    localparam logic [X_W-1:0] H_LAST       = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [X_W-1:0] H_SYNC_FIRST = X_W'(H_ACTIVE + H_FRONT_PORCH);
    localparam logic [X_W-1:0] H_SYNC_LAST  = X_W'(H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE - 1);
    localparam logic [Y_W-1:0] V_LAST       = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT_LAST   = Y_W'(V_ACTIVE - 1);
    localparam logic [Y_W-1:0] V_SYNC_FIRST = Y_W'(V_ACTIVE + V_FRONT_PORCH);
    localparam logic [Y_W-1:0] V_SYNC_LAST  = Y_W'(V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE - 1);

    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
        $error("vga_timing: PIPE_DELAY must be in 0..4");
    end

    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        if (ce) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d     = '0;
                    frame_d = frame_q + 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
        end
    end

    logic h_sync_raw, v_sync_raw, active_raw;
    logic hs_lvl, vs_lvl;

    always_comb begin
        h_sync_raw = (x_q >= H_SYNC_FIRST) && (x_q <= H_SYNC_LAST);
        v_sync_raw = (y_q >= V_SYNC_FIRST) && (y_q <= V_SYNC_LAST);
        active_raw = (x_q <= H_ACT_LAST) && (y_q <= V_ACT_LAST);
        hs_lvl     = h_sync_raw ^ SYNC_ACTIVE_LOW;
        vs_lvl     = v_sync_raw ^ SYNC_ACTIVE_LOW;
    end

    assign vga.pixel_x       = x_q;
    assign vga.pixel_y       = y_q;
    assign vga.frame_counter = frame_q;
    assign vga.line_start    = ce && (x_q == '0);
    assign vga.frame_start   = ce && (x_q == '0) && (y_q == '0);

    if (PIPE_DELAY == 0) begin : g_no_pipe
        assign vga.active = active_raw;
        assign vga.hsync  = hs_lvl;
        assign vga.vsync  = vs_lvl;
    end else begin : g_pipe
        // Sync levels are stored already polarity-adjusted, so reset loads the deasserted level.
        logic [PIPE_DELAY-1:0] act_q, act_d;
        logic [PIPE_DELAY-1:0] hs_q, hs_d;
        logic [PIPE_DELAY-1:0] vs_q, vs_d;

        always_comb begin
            act_d = act_q;
            hs_d  = hs_q;
            vs_d  = vs_q;
            if (ce) begin
                act_d[0] = active_raw;
                hs_d[0]  = hs_lvl;
                vs_d[0]  = vs_lvl;
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    act_d[i] = act_q[i-1];
                    hs_d[i]  = hs_q[i-1];
                    vs_d[i]  = vs_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                act_q <= '0;
                hs_q  <= {PIPE_DELAY{SYNC_ACTIVE_LOW}};
                vs_q  <= {PIPE_DELAY{SYNC_ACTIVE_LOW}};
            end else begin
                act_q <= act_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
            end
        end

        assign vga.active = act_q[PIPE_DELAY-1];
        assign vga.hsync  = hs_q[PIPE_DELAY-1];
        assign vga.vsync  = vs_q[PIPE_DELAY-1];
    end
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: one full-size instance for line timing, and two small-raster
// instances (16x8 totals, pipe depth 0 and 3) for frame, clock-enable, reset and wrap cases.
module tb_vga_timing;
    logic clk, rst, ce;
    int   n_cmp, n_bad;
    int   idx, m;
    logic c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_if #(.X_W(10), .Y_W(10), .F_W(5)) if_def ();
    vga_timing_if #(.X_W(4),  .Y_W(3),  .F_W(5)) if_s0 ();
    vga_timing_if #(.X_W(4),  .Y_W(3),  .F_W(5)) if_s3 ();

    vga_timing u_def (.clk(clk), .rst(rst), .ce(ce), .vga(if_def));

    vga_timing #(
        .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(3),
        .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .PIPE_DELAY(0)
    ) u_s0 (.clk(clk), .rst(rst), .ce(ce), .vga(if_s0));

    vga_timing #(
        .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(3),
        .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .PIPE_DELAY(3)
    ) u_s3 (.clk(clk), .rst(rst), .ce(ce), .vga(if_s3));

    typedef struct {
        int step; int x; int y;
        logic act; logic hs; logic ls; logic fs;
    } dvec_t;

    typedef struct {
        int step; int x; int y; int fc;
        logic ls; logic fs;
        logic hs0; logic vs0; logic act0;
        logic hs3; logic vs3; logic act3;
    } svec_t;

    dvec_t dtbl[$];
    svec_t stbl[$];

    task automatic chkn(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic c_in);
        @(negedge clk);
        rst = r;
        ce  = c_in;
        #1;
    endtask

    // Small raster: sync x in [10,12], sync y in [5,6], visible x<8, y<4, sync active low.
    function automatic logic m_hs(input int k);
        int x;
        x = k % 16;
        return !(x >= 10 && x <= 12);
    endfunction

    function automatic logic m_vs(input int k);
        int y;
        y = (k / 16) % 8;
        return !(y >= 5 && y <= 6);
    endfunction

    function automatic logic m_act(input int k);
        return ((k % 16) < 8) && (((k / 16) % 8) < 4);
    endfunction

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; ce = 1'b0;

        dtbl.push_back('{0,   0,   0, 0, 1, 1, 1});
        dtbl.push_back('{1,   1,   0, 1, 1, 0, 0});
        dtbl.push_back('{2,   2,   0, 1, 1, 0, 0});
        dtbl.push_back('{640, 640, 0, 1, 1, 0, 0});
        dtbl.push_back('{641, 641, 0, 0, 1, 0, 0});
        dtbl.push_back('{656, 656, 0, 0, 1, 0, 0});
        dtbl.push_back('{657, 657, 0, 0, 0, 0, 0});
        dtbl.push_back('{752, 752, 0, 0, 0, 0, 0});
        dtbl.push_back('{753, 753, 0, 0, 1, 0, 0});
        dtbl.push_back('{799, 799, 0, 0, 1, 0, 0});
        dtbl.push_back('{800, 0,   1, 0, 1, 1, 0});
        dtbl.push_back('{801, 1,   1, 1, 1, 0, 0});

        //                step  x  y fc ls fs hs0 vs0 a0 hs3 vs3 a3
        stbl.push_back('{0,    0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0});
        stbl.push_back('{2,    2, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0});
        stbl.push_back('{3,    3, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1});
        stbl.push_back('{9,    9, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1});
        stbl.push_back('{10,  10, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1});
        stbl.push_back('{12,  12, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0});
        stbl.push_back('{13,  13, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0});
        stbl.push_back('{15,  15, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0});
        stbl.push_back('{16,   0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 0});
        stbl.push_back('{79,  15, 4, 0, 0, 0, 1, 1, 0, 0, 1, 0});
        stbl.push_back('{80,   0, 5, 0, 1, 0, 1, 0, 0, 1, 1, 0});
        stbl.push_back('{83,   3, 5, 0, 0, 0, 1, 0, 0, 1, 0, 0});
        stbl.push_back('{111, 15, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        stbl.push_back('{112,  0, 7, 0, 1, 0, 1, 1, 0, 1, 0, 0});
        stbl.push_back('{115,  3, 7, 0, 0, 0, 1, 1, 0, 1, 1, 0});
        stbl.push_back('{127, 15, 7, 0, 0, 0, 1, 1, 0, 0, 1, 0});
        stbl.push_back('{128,  0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0});
        stbl.push_back('{131,  3, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1});
        stbl.push_back('{256,  0, 0, 2, 1, 1, 1, 1, 1, 1, 1, 0});

        // Reset held for three edges with ce=1.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1);
            if (i >= 1) begin
                chkn("rst_def_x", 32'(if_def.pixel_x), 0);
                chkn("rst_def_y", 32'(if_def.pixel_y), 0);
                chkn("rst_def_fc", 32'(if_def.frame_counter), 0);
                chk1("rst_def_act", if_def.active, 1'b0);
                chk1("rst_def_hs", if_def.hsync, 1'b1);
                chk1("rst_def_vs", if_def.vsync, 1'b1);
                chk1("rst_s3_act", if_s3.active, 1'b0);
                chk1("rst_s3_hs", if_s3.hsync, 1'b1);
                chk1("rst_s3_vs", if_s3.vsync, 1'b1);
                chkn("rst_s0_x", 32'(if_s0.pixel_x), 0);
                chk1("rst_s0_hs", if_s0.hsync, 1'b1);
                chk1("rst_s0_vs", if_s0.vsync, 1'b1);
            end
        end

        // Full-size line timing.
        idx = 0;
        for (int n = 0; n <= 801; n++) begin
            drive(1'b0, 1'b1);
            if (idx < dtbl.size() && dtbl[idx].step == n) begin
                chkn("def_x", 32'(if_def.pixel_x), dtbl[idx].x);
                chkn("def_y", 32'(if_def.pixel_y), dtbl[idx].y);
                chk1("def_act", if_def.active, dtbl[idx].act);
                chk1("def_hs", if_def.hsync, dtbl[idx].hs);
                chk1("def_vs", if_def.vsync, 1'b1);
                chk1("def_ls", if_def.line_start, dtbl[idx].ls);
                chk1("def_fs", if_def.frame_start, dtbl[idx].fs);
                chkn("def_fc", 32'(if_def.frame_counter), 0);
                idx++;
            end
        end
        chkn("def_vectors_applied", idx, dtbl.size());

        // Small raster frame timing, pipe depths 0 and 3.
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        idx = 0;
        for (int n = 0; n <= 256; n++) begin
            drive(1'b0, 1'b1);
            if (idx < stbl.size() && stbl[idx].step == n) begin
                chkn("s_x", 32'(if_s0.pixel_x), stbl[idx].x);
                chkn("s_y", 32'(if_s0.pixel_y), stbl[idx].y);
                chkn("s_fc", 32'(if_s0.frame_counter), stbl[idx].fc);
                chk1("s_ls", if_s0.line_start, stbl[idx].ls);
                chk1("s_fs", if_s0.frame_start, stbl[idx].fs);
                chk1("s0_hs", if_s0.hsync, stbl[idx].hs0);
                chk1("s0_vs", if_s0.vsync, stbl[idx].vs0);
                chk1("s0_act", if_s0.active, stbl[idx].act0);
                chkn("s3_x", 32'(if_s3.pixel_x), stbl[idx].x);
                chk1("s3_hs", if_s3.hsync, stbl[idx].hs3);
                chk1("s3_vs", if_s3.vsync, stbl[idx].vs3);
                chk1("s3_act", if_s3.active, stbl[idx].act3);
                idx++;
            end
        end
        chkn("s_vectors_applied", idx, stbl.size());

        // Reset with ce=0 still clears the frame counter (it was 2).
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chkn("rst_ce0_fc", 32'(if_s0.frame_counter), 0);
        chkn("rst_ce0_x", 32'(if_s3.pixel_x), 0);

        // Clock enable toggling 1,0,1,0: state advances only on ce=1 edges.
        m = 0;
        for (int k = 0; k < 300; k++) begin
            c = (k % 2 == 0);
            drive(1'b0, c);
            chkn("ce_x", 32'(if_s0.pixel_x), m % 16);
            chkn("ce_y", 32'(if_s0.pixel_y), (m / 16) % 8);
            chkn("ce_fc", 32'(if_s0.frame_counter), (m / 128) % 32);
            chk1("ce_ls", if_s0.line_start, c && (m % 16 == 0));
            chk1("ce_fs", if_s0.frame_start, c && (m % 128 == 0));
            chk1("ce_s0_hs", if_s0.hsync, m_hs(m));
            chk1("ce_s0_vs", if_s0.vsync, m_vs(m));
            chk1("ce_s0_act", if_s0.active, m_act(m));
            chk1("ce_s3_hs", if_s3.hsync, (m < 3) ? 1'b1 : m_hs(m - 3));
            chk1("ce_s3_vs", if_s3.vsync, (m < 3) ? 1'b1 : m_vs(m - 3));
            chk1("ce_s3_act", if_s3.active, (m < 3) ? 1'b0 : m_act(m - 3));
            if (c) m++;
        end

        // Mid-frame reset (raster at x=6, y=1 of frame 1), then 32 frames to wrap.
        drive(1'b1, 1'b1);
        for (int n = 0; n <= 4096; n++) begin
            drive(1'b0, 1'b1);
            if (n == 0) begin
                chkn("mid_x", 32'(if_s0.pixel_x), 0);
                chkn("mid_y", 32'(if_s0.pixel_y), 0);
                chkn("mid_fc", 32'(if_s0.frame_counter), 0);
                chk1("mid_fs", if_s0.frame_start, 1'b1);
                chk1("mid_s3_act", if_s3.active, 1'b0);
                chk1("mid_s3_hs", if_s3.hsync, 1'b1);
            end
            if (n == 127) begin
                chkn("mid_end_x", 32'(if_s0.pixel_x), 15);
                chkn("mid_end_y", 32'(if_s0.pixel_y), 7);
                chkn("mid_end_fc", 32'(if_s0.frame_counter), 0);
            end
            if (n == 128) chkn("mid_next_fc", 32'(if_s0.frame_counter), 1);
            if (n == 3968) chkn("wrap_fc31", 32'(if_s3.frame_counter), 31);
            if (n == 4095) chkn("wrap_fc31_end", 32'(if_s0.frame_counter), 31);
            if (n == 4096) begin
                chkn("wrap_fc0", 32'(if_s0.frame_counter), 0);
                chkn("wrap_x", 32'(if_s0.pixel_x), 0);
                chkn("wrap_y", 32'(if_s0.pixel_y), 0);
                chk1("wrap_fs", if_s0.frame_start, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
